// File: rtl/imm_ext_pkg.sv
// Shared immediate-type encodings and XLEN legality check for imm_ext_pipe.
package imm_ext_pkg;

   typedef logic [2:0] imm_src_t;

   localparam imm_src_t IMM_I     = 3'b000;
   localparam imm_src_t IMM_S     = 3'b001;
   localparam imm_src_t IMM_B     = 3'b010;
   localparam imm_src_t IMM_U     = 3'b011;
   localparam imm_src_t IMM_J     = 3'b100;
   localparam imm_src_t IMM_SHAMT = 3'b101;
   localparam imm_src_t IMM_ZIMM  = 3'b110;
   localparam imm_src_t IMM_RSV   = 3'b111;

   localparam int XLEN_RV32 = 32;
   localparam int XLEN_RV64 = 64;

   function automatic bit xlen_legal(input int xlen);
      return (xlen == XLEN_RV32) || (xlen == XLEN_RV64);
   endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry elastic buffer: output register plus one skid register.
// in_ready comes straight from the skid-valid flop, so it never depends on out_ready.
module imm_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         skid_valid;
   logic [W-1:0] skid_data;
   logic         accept;
   logic         fire;
   logic         load_out;

   assign in_ready = !skid_valid;
   assign accept   = in_valid && !skid_valid;
   assign fire     = out_valid && out_ready;
   assign load_out = fire || !out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (load_out) begin
         // A held skid beat always goes first; input is blocked while it exists.
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            skid_valid <= 1'b0;
         end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined RISC-V immediate generator with valid/ready handshake and skid buffer.
// Define IMM_EXT_ERR_EN to register a reserved-ImmSrc flag alongside each beat.
module imm_ext_pipe
   import imm_ext_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:7]      Instr,
   input  imm_src_t         ImmSrc,
   input  logic [TAG_W-1:0] InTag,
   input  logic             InValid,
   output logic             InReady,
   output logic [XLEN-1:0]  ImmExt,
   output logic [TAG_W-1:0] OutTag,
   output logic             ImmErr,
   output logic             OutValid,
   input  logic             OutReady
);

   if (!xlen_legal(XLEN)) begin : g_xlen_chk
      $error("imm_ext_pipe: XLEN must be 32 or 64");
   end

   logic [31:0]     raw;
   logic            sext;
   logic [XLEN-1:0] imm_d;

   // raw holds the 32-bit form; sext says whether bit 31 replicates above it.
   always_comb begin
      raw  = '0;
      sext = 1'b0;
      case (ImmSrc)
         IMM_I: begin
            raw  = {{20{Instr[31]}}, Instr[31:20]};
            sext = 1'b1;
         end
         IMM_S: begin
            raw  = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
            sext = 1'b1;
         end
         IMM_B: begin
            raw  = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
            sext = 1'b1;
         end
         IMM_U: begin
            raw  = {Instr[31:12], 12'b0};
            sext = 1'b1;
         end
         IMM_J: begin
            raw  = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
            sext = 1'b1;
         end
         IMM_SHAMT: begin
            if (XLEN == XLEN_RV64) raw = {26'b0, Instr[25:20]};
            else                   raw = {27'b0, Instr[24:20]};
         end
         IMM_ZIMM: raw = {27'b0, Instr[19:15]};
         default:  raw = '0;
      endcase
      imm_d       = {XLEN{sext & raw[31]}};
      imm_d[31:0] = raw;
   end

`ifdef IMM_EXT_ERR_EN
   localparam int PAY_W = XLEN + TAG_W + 1;
   logic [PAY_W-1:0] pay_in;
   logic [PAY_W-1:0] pay_out;

   assign pay_in                   = {ImmSrc == IMM_RSV, InTag, imm_d};
   assign {ImmErr, OutTag, ImmExt} = pay_out;
`else
   localparam int PAY_W = XLEN + TAG_W;
   logic [PAY_W-1:0] pay_in;
   logic [PAY_W-1:0] pay_out;

   assign pay_in           = {InTag, imm_d};
   assign {OutTag, ImmExt} = pay_out;
   assign ImmErr           = 1'b0;
`endif

   imm_skid_buf #(
      .W (PAY_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (InValid),
      .in_ready  (InReady),
      .in_data   (pay_in),
      .out_valid (OutValid),
      .out_ready (OutReady),
      .out_data  (pay_out)
   );

endmodule
